// File: rtl/l2_pkg.sv
// Shared definitions for the Lab2 multi-cycle add/subtract unit:
// FSM state encoding and LED bit positions.
package l2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } l2_state_e;

  localparam int unsigned LED_RDY      = 0;
  localparam int unsigned LED_STATE_LO = 1;
  localparam int unsigned LED_STATE_HI = 2;
  localparam int unsigned LED_BUSY     = 3;
  localparam int unsigned LED_NEG      = 4;
  localparam int unsigned LED_ZERO     = 5;
  localparam int unsigned LED_COUT     = 6;
  localparam int unsigned LED_OVF      = 7;

endpackage

// File: rtl/l2_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; also
// exposes the carry into the top bit so the caller can derive signed overflow.
module l2_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/l2_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract: CHUNK bits per clock, lowest chunk first,
// with registered flags, busy level and a one-cycle ready pulse.
module l2_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             Gl_rst,
  input  logic             Gl_adder_start,
  input  logic             Gl_subtract,
  input  logic [WIDTH-1:0] Gl_r1,
  input  logic [WIDTH-1:0] Gl_r2,
  output logic [WIDTH-1:0] L2_adder_data,
  output logic             L2_adder_rdy,
  output logic             L2_busy,
  output logic             L2_cout,
  output logic             L2_ovf,
  output logic             L2_zero,
  output logic             L2_neg,
  output logic [7:0]       L2_led
);
  import l2_pkg::*;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("l2_addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  l2_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, data_q, data_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             rdy_q, rdy_d, busy_q, busy_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic [CHUNK-1:0] sum_chunk;
  logic             c_out, c_msb;
  logic [WIDTH-1:0] res_next;

  l2_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_q[int'(idx_q)*CHUNK +: CHUNK]),
    .b        (b_q[int'(idx_q)*CHUNK +: CHUNK]),
    .cin      (carry_q),
    .sum      (sum_chunk),
    .cout     (c_out),
    .c_msb_in (c_msb)
  );

  always_comb begin
    res_next = res_q;
    res_next[int'(idx_q)*CHUNK +: CHUNK] = sum_chunk;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    data_d  = data_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Gl_adder_start) begin
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          state_d = ST_RUN;
          a_d     = Gl_r1;
          b_d     = Gl_subtract ? ~Gl_r2 : Gl_r2;
          carry_d = Gl_subtract;
          idx_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        res_d   = res_next;
        carry_d = c_out;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          rdy_d   = 1'b1;
          data_d  = res_next;
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
          zero_d  = (res_next == '0);
          neg_d   = res_next[WIDTH-1];
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Gl_rst) begin
    if (Gl_rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign L2_adder_data = data_q;
  assign L2_adder_rdy  = rdy_q;
  assign L2_busy       = busy_q;
  assign L2_cout       = cout_q;
  assign L2_ovf        = ovf_q;
  assign L2_zero       = zero_q;
  assign L2_neg        = neg_q;

  always_comb begin
    L2_led                            = '0;
    L2_led[LED_RDY]                   = rdy_q;
    L2_led[LED_STATE_HI:LED_STATE_LO] = 2'(state_q);
    L2_led[LED_BUSY]                  = busy_q;
    L2_led[LED_NEG]                   = neg_q;
    L2_led[LED_ZERO]                  = zero_q;
    L2_led[LED_COUT]                  = cout_q;
    L2_led[LED_OVF]                   = ovf_q;
  end

endmodule
